// File: rtl/dmem_responder_if.sv
// Bus bundle for dmem_responder: request strobe, operands, read data and status.
// The master modport drives requests; the slave modport is the responder side.
interface dmem_responder_if;
  logic        req;
  logic        write_enabled;
  logic [31:0] addr;
  logic [31:0] w_data;
  logic [31:0] r_data;
  logic [1:0]  status;

  modport master (
    output req,
    output write_enabled,
    output addr,
    output w_data,
    input  r_data,
    input  status
  );

  modport slave (
    input  req,
    input  write_enabled,
    input  addr,
    input  w_data,
    output r_data,
    output status
  );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency single-port data memory responder.
// A request accepted in IDLE or RESP is held BUSY for LATENCY cycles, then
// the access is performed and DONE (or ERROR) is shown for one cycle.
// Optional macro DMEM_ERR_CHECK_EN: misaligned or out-of-range addresses
// complete with ERROR status, no write and r_data unchanged. Without it the
// low address bits are ignored and the word index wraps modulo DEPTH_WORDS.
// Storage is deliberately not reset; only control state and r_data are.
module dmem_responder #(
  parameter int LATENCY     = 2,
  parameter int DEPTH_WORDS = 1024
) (
  input logic             clk,
  input logic             rst,
  dmem_responder_if.slave bus
);

  localparam int         IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_BUSY  = 2'b01;
  localparam logic [1:0] ST_DONE  = 2'b10;
  localparam logic [1:0] ST_ERROR = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t             state_r;
  logic [3:0]         cnt_r;
  logic [31:0]        addr_r;
  logic [31:0]        wdata_r;
  logic               we_r;
  logic [1:0]         status_r;
  logic [31:0]        rdata_r;

  logic [31:0]        mem_r [DEPTH_WORDS];

  logic [IDX_W-1:0]   idx_s;
  logic               complete_s;
  logic               err_s;
  logic               mem_we_s;

`ifdef DMEM_ERR_CHECK_EN
  localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH_WORDS) << 2;
`else
  // Byte-offset and high address bits have no function when errors are not checked.
  logic addr_unused_s;
  assign addr_unused_s = ^{addr_r[31:IDX_W+2], addr_r[1:0]};
`endif

  // Word index, completion edge, error decision and write strobe from latched operands.
  always_comb begin
    idx_s      = addr_r[IDX_W+1:2];
    complete_s = (state_r == BUSY) && (cnt_r == 4'd0);
`ifdef DMEM_ERR_CHECK_EN
    if ((addr_r[1:0] != 2'b00) || ({1'b0, addr_r} >= ADDR_LIMIT)) begin
      err_s = 1'b1;
    end else begin
      err_s = 1'b0;
    end
`else
    err_s = 1'b0;
`endif
    mem_we_s = complete_s && we_r && !err_s;
  end

  // Storage array: written only on the completion edge of a good write; never reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_r[idx_s] <= wdata_r;
    end
  end

  // Control FSM with registered status, operand latch, latency counter and read data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r  <= IDLE;
      cnt_r    <= 4'd0;
      addr_r   <= 32'd0;
      wdata_r  <= 32'd0;
      we_r     <= 1'b0;
      status_r <= ST_IDLE;
      rdata_r  <= 32'd0;
    end else begin
      case (state_r)
        IDLE, RESP: begin
          if (bus.req) begin
            addr_r   <= bus.addr;
            wdata_r  <= bus.w_data;
            we_r     <= bus.write_enabled;
            cnt_r    <= CNT_LOAD;
            state_r  <= BUSY;
            status_r <= ST_BUSY;
          end else begin
            state_r  <= IDLE;
            status_r <= ST_IDLE;
          end
        end
        BUSY: begin
          // Requests are ignored here; operands stay frozen until completion.
          if (cnt_r == 4'd0) begin
            state_r  <= RESP;
            status_r <= err_s ? ST_ERROR : ST_DONE;
            if (!we_r && !err_s) begin
              rdata_r <= mem_r[idx_s];
            end
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        default: begin
          state_r  <= IDLE;
          status_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.r_data = rdata_r;
  assign bus.status = status_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (LATENCY=2, DEPTH_WORDS=1024).
// Covers reset/idle, write then read, back-to-back accept in RESP, request
// ignore while BUSY, misaligned read (both macro builds) and reset mid-write.
module tb_dmem_responder;

  localparam int LAT = 2;

  logic clk;
  logic rst;
  int   n_total;
  int   n_pass;
  int   n_fail;

  dmem_responder_if bus ();

  dmem_responder #(
    .LATENCY     (LAT),
    .DEPTH_WORDS (1024)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete access from IDLE/RESP: BUSY for LAT cycles, final status, then IDLE.
  task automatic do_access(input string tag, input logic w, input logic [31:0] a,
                           input logic [31:0] d, input logic [1:0] fin,
                           input logic [31:0] exp_rd);
    bus.req           = 1'b1;
    bus.write_enabled = w;
    bus.addr          = a;
    bus.w_data        = d;
    tick();
    bus.req = 1'b0;
    chk({tag, "_busy0"}, {30'd0, bus.status}, 32'h1);
    for (int i = 1; i < LAT; i++) begin
      tick();
      chk({tag, "_busyn"}, {30'd0, bus.status}, 32'h1);
    end
    tick();
    chk({tag, "_fin"}, {30'd0, bus.status}, {30'd0, fin});
    chk({tag, "_rdata"}, bus.r_data, exp_rd);
    tick();
    chk({tag, "_idle"}, {30'd0, bus.status}, 32'h0);
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    n_fail  = 0;
    bus.req           = 1'b0;
    bus.write_enabled = 1'b0;
    bus.addr          = 32'd0;
    bus.w_data        = 32'd0;

    // Reset and idle
    rst = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    chk("rst_status", {30'd0, bus.status}, 32'h0);
    chk("rst_rdata", bus.r_data, 32'h0);
    tick();
    tick();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_status", {30'd0, bus.status}, 32'h0);
    end

    // Write then read
    do_access("wr10", 1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 32'h0);
    do_access("rd10", 1'b0, 32'h10, 32'h0, 2'b10, 32'hDEADBEEF);
    do_access("wr08", 1'b1, 32'h08, 32'h5555AAAA, 2'b10, 32'hDEADBEEF);

    // Back-to-back: write 0x20, req held through BUSY and RESP, read 0x20 accepted in RESP
    bus.req           = 1'b1;
    bus.write_enabled = 1'b1;
    bus.addr          = 32'h20;
    bus.w_data        = 32'hCAFEF00D;
    tick();
    chk("b2b_busy0", {30'd0, bus.status}, 32'h1);
    bus.write_enabled = 1'b0;
    bus.w_data        = 32'h0BAD0BAD;
    tick();
    chk("b2b_busy1", {30'd0, bus.status}, 32'h1);
    tick();
    chk("b2b_done0", {30'd0, bus.status}, 32'h2);
    chk("b2b_rd_hold", bus.r_data, 32'hDEADBEEF);
    tick();
    chk("b2b_busy2", {30'd0, bus.status}, 32'h1);
    bus.req = 1'b0;
    tick();
    chk("b2b_busy3", {30'd0, bus.status}, 32'h1);
    tick();
    chk("b2b_done1", {30'd0, bus.status}, 32'h2);
    chk("b2b_rdata", bus.r_data, 32'hCAFEF00D);
    tick();
    chk("b2b_idle", {30'd0, bus.status}, 32'h0);

    // Request pulse during BUSY is ignored
    bus.req           = 1'b1;
    bus.write_enabled = 1'b0;
    bus.addr          = 32'h10;
    tick();
    chk("ign_busy0", {30'd0, bus.status}, 32'h1);
    bus.addr = 32'h20;
    tick();
    chk("ign_busy1", {30'd0, bus.status}, 32'h1);
    bus.req = 1'b0;
    tick();
    chk("ign_done", {30'd0, bus.status}, 32'h2);
    chk("ign_rdata", bus.r_data, 32'hDEADBEEF);
    tick();
    chk("ign_idle0", {30'd0, bus.status}, 32'h0);
    tick();
    chk("ign_idle1", {30'd0, bus.status}, 32'h0);

    // Misaligned read 0x13 after r_data holds 0xCAFEF00D
    do_access("rd20", 1'b0, 32'h20, 32'h0, 2'b10, 32'hCAFEF00D);
`ifdef DMEM_ERR_CHECK_EN
    do_access("rd13", 1'b0, 32'h13, 32'h0, 2'b11, 32'hCAFEF00D);
`else
    do_access("rd13", 1'b0, 32'h13, 32'h0, 2'b10, 32'hDEADBEEF);
`endif

    // Reset during BUSY of a write aborts it
    bus.req           = 1'b1;
    bus.write_enabled = 1'b1;
    bus.addr          = 32'h08;
    bus.w_data        = 32'h00001234;
    tick();
    bus.req = 1'b0;
    chk("mid_busy", {30'd0, bus.status}, 32'h1);
    rst = 1'b0;
    #1;
    chk("mid_rst_status", {30'd0, bus.status}, 32'h0);
    chk("mid_rst_rdata", bus.r_data, 32'h0);
    tick();
    tick();
    @(negedge clk);
    rst = 1'b1;
    do_access("rd08", 1'b0, 32'h08, 32'h0, 2'b10, 32'h5555AAAA);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have parameter LATENCY, default 2, meaning the number of BUSY cycles per access (legal range 1..15).
REQ-002 The block SHALL have parameter DEPTH_WORDS, default 1024, meaning the number of 32-bit storage words (power of two).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have port req, input, 1 bit: access request strobe.
REQ-006 The block SHALL have port write_enabled, input, 1 bit: 1 = write, 0 = read; qualified by req.
REQ-007 The block SHALL have port addr, input, 32 bits: byte address.
REQ-008 The block SHALL have port w_data, input, 32 bits: write data.
REQ-009 The block SHALL have port r_data, output, 32 bits: registered read data.
REQ-010 The block SHALL have port status, output, 2 bits: 00 IDLE, 01 BUSY, 10 DONE, 11 ERROR.

Function
REQ-011 The FSM SHALL have states IDLE, BUSY and RESP; status is a registered function of the state (RESP drives DONE or ERROR).
REQ-012 The block SHALL accept a request on a rising edge where req=1 and the state is IDLE or RESP, latching addr, w_data and write_enabled on that edge.
REQ-013 A request SHALL be ignored while BUSY; the latched operands SHALL NOT change while BUSY.
REQ-014 After acceptance at edge T, status SHALL read BUSY for exactly LATENCY cycles, with a down-counter loaded with LATENCY-1 at T.
REQ-015 At edge T+LATENCY the block SHALL perform the access, enter RESP, and drive DONE (or ERROR) for exactly one cycle.
REQ-016 In RESP the next state SHALL be BUSY if req=1 (back-to-back accept), otherwise IDLE.
REQ-017 A read SHALL load r_data with mem[addr[log2(DEPTH_WORDS)+1:2]] at edge T+LATENCY.
REQ-018 A write SHALL store w_data at the same word index at edge T+LATENCY, leaving r_data unchanged.
REQ-019 r_data SHALL hold its value until the next successful read completes.
REQ-020 A read of a word written by the immediately preceding access SHALL return the new value.

Reset
REQ-021 When rst=0, the block SHALL asynchronously enter IDLE, clear the counter and latched operands, and drive status=00 and r_data=0.
REQ-022 Reset asserted mid-access SHALL abort the access with no memory write.
REQ-023 Storage contents SHALL NOT be reset.
REQ-024 The first request SHALL be accepted on the first rising edge after rst rises with req=1.

Configuration
REQ-025 With macro DMEM_ERR_CHECK_EN defined, an accepted access with addr[1:0]!=0 or addr >= 4*DEPTH_WORDS SHALL complete with status=11 in RESP (same latency), with no memory write and r_data unchanged.
REQ-026 With DMEM_ERR_CHECK_EN undefined, addr[1:0] SHALL be ignored, the word index SHALL wrap modulo DEPTH_WORDS, and status SHALL never be 11.

Verification
REQ-027 Reset then idle: rst=0 -> status=00, r_data=0; rst=1 with req=0 for 5 cycles -> status stays 00.
REQ-028 Write/read with LATENCY=2: write 0xDEADBEEF to addr 0x10, then read 0x10 -> status 01,01,10 per access; r_data=0xDEADBEEF on the DONE cycle of the read.
REQ-029 Back-to-back: req held 1 across the RESP cycle -> the second access is accepted in RESP, status sequence 01,01,10,01,01,10 with no IDLE gap.
REQ-030 Busy ignore: pulse req with addr 0x20 during BUSY of a read to 0x10 -> no extra access; r_data reflects 0x10 only.
REQ-031 Error case, DMEM_ERR_CHECK_EN defined: read 0x13 -> status 11 for one cycle, r_data unchanged. Error case, undefined: the same read returns mem[4] with status 10.
REQ-032 Reset mid-write: rst=0 during BUSY of a write of 0x1234 to 0x8 -> status=00, and a later read of 0x8 returns the prior contents.
